// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul tile scheduler and the BRAM wrapper that owns A/B.
// Holds the FSM encoding, the per-state control word and the tiling helper functions.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRIME    = 3'd1,
    ST_RUN      = 3'd2,
    ST_STEP_CLR = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_EMIT     = 3'd5,
    ST_FIN      = 3'd6
  } state_e;

  typedef struct packed {
    logic enb;
    logic core_en;
    logic core_rst_n;
    logic core_reset_acc;
    logic out_valid;
    logic done;
    logic busy;
  } ctrl_t;

  function automatic int unsigned k_steps_of(input int unsigned inner_dim,
                                             input int unsigned block_size);
    return inner_dim / block_size;
  endfunction

  function automatic int unsigned tiles_of(input int unsigned dim,
                                           input int unsigned block_size);
    return (dim + block_size - 1) / block_size;
  endfunction

  // Number of BRAM words one operand occupies; must fit in 2^ADDR_WIDTH.
  function automatic int unsigned addr_span(input int unsigned k_steps,
                                            input int unsigned tiles);
    return k_steps * tiles;
  endfunction

  // Control outputs seen while the FSM sits in a given state.
  function automatic ctrl_t ctrl_of(input state_e st);
    ctrl_t c;
    c                = '0;
    c.busy           = (st != ST_IDLE);
    c.enb            = (st != ST_IDLE);
    c.core_rst_n     = (st != ST_IDLE) && (st != ST_STEP_CLR);
    c.core_reset_acc = (st != ST_IDLE) && (st != ST_PRIME);
    c.core_en        = (st == ST_RUN) || (st == ST_DRAIN);
    c.out_valid      = (st == ST_EMIT);
    c.done           = (st == ST_FIN);
    return c;
  endfunction

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// Tile result stream from the scheduler to the sink that captures the core output.
interface matmul_tile_scheduler_if #(
  parameter int unsigned CNT_WIDTH = 16
) ();

  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] out_row;
  logic [CNT_WIDTH-1:0] out_col;

  modport master (output out_valid, output out_row, output out_col, input out_ready);
  modport slave  (input out_valid, input out_row, input out_col, output out_ready);

endinterface

// File: rtl/matmul_tile_counter.sv
// Nested k / col / row counters for the tile walk, with wrap and last-element flags.
// Exposes next-cycle values so addresses can be registered on the same edge as the count.
module matmul_tile_counter
  import matmul_pkg::*;
#(
  parameter int unsigned K_STEPS   = 4,
  parameter int unsigned ROW_TILES = 2,
  parameter int unsigned COL_TILES = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 k_inc,
  input  logic                 tile_inc,
  output logic [CNT_WIDTH-1:0] row,
  output logic [CNT_WIDTH-1:0] col,
  output logic [CNT_WIDTH-1:0] k_nxt,
  output logic [CNT_WIDTH-1:0] row_nxt,
  output logic [CNT_WIDTH-1:0] col_nxt,
  output logic                 k_last,
  output logic                 tile_last
);

  localparam logic [CNT_WIDTH-1:0] K_MAX   = CNT_WIDTH'(K_STEPS - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_MAX = CNT_WIDTH'(ROW_TILES - 1);
  localparam logic [CNT_WIDTH-1:0] COL_MAX = CNT_WIDTH'(COL_TILES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] k_q, row_q, col_q;
  logic [CNT_WIDTH-1:0] k_d, row_d, col_d;
  logic                 col_last;

  assign k_last    = (k_q == K_MAX);
  assign col_last  = (col_q == COL_MAX);
  assign tile_last = col_last && (row_q == ROW_MAX);

  // NOTE: every _d is given its current value first, so no path leaves it unassigned (no latch).
  always_comb begin
    k_d   = k_q;
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      k_d   = '0;
      row_d = '0;
      col_d = '0;
    end else if (tile_inc) begin
      k_d = '0;
      if (col_last) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end else if (k_inc) begin
      k_d = k_last ? '0 : k_q + ONE;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      k_q   <= k_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign k_nxt   = k_d;
  assign row_nxt = row_d;
  assign col_nxt = col_d;

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Sequences one C = A x B job: walks output tiles row-major, drives the A/B BRAM reads and
// core clears for each K step, hands each finished tile to the sink and pulses done at the end.
module matmul_tile_scheduler
  import matmul_pkg::*;
#(
  parameter int unsigned K_STEPS      = 4,
  parameter int unsigned ROW_TILES    = 2,
  parameter int unsigned COL_TILES    = 3,
  parameter int unsigned ADDR_WIDTH_A = 8,
  parameter int unsigned ADDR_WIDTH_B = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    a_enb,
  output logic                    b_enb,
  output logic [ADDR_WIDTH_A-1:0] a_addrb,
  output logic [ADDR_WIDTH_B-1:0] b_addrb,
  output logic                    core_en,
  output logic                    core_rst_n,
  output logic                    core_reset_acc,
  input  logic                    step_done,
  input  logic                    acc_done,
  matmul_tile_scheduler_if.master tile_if,
  output logic                    err
);

  localparam logic [CNT_WIDTH-1:0] K_STRIDE = CNT_WIDTH'(K_STEPS);

  state_e                  state_q, state_d;
  ctrl_t                   ctrl_q, ctrl_d;
  logic [ADDR_WIDTH_A-1:0] a_addrb_q, a_addrb_d;
  logic [ADDR_WIDTH_B-1:0] b_addrb_q, b_addrb_d;
  logic [CNT_WIDTH-1:0]    out_row_q, out_row_d;
  logic [CNT_WIDTH-1:0]    out_col_q, out_col_d;
  logic                    err_q, err_d;

  logic                    cnt_clr, k_inc, tile_inc;
  logic [CNT_WIDTH-1:0]    row, col, k_nxt, row_nxt, col_nxt;
  logic                    k_last, tile_last;

  matmul_tile_counter #(
    .K_STEPS  (K_STEPS),
    .ROW_TILES(ROW_TILES),
    .COL_TILES(COL_TILES),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .k_inc    (k_inc),
    .tile_inc (tile_inc),
    .row      (row),
    .col      (col),
    .k_nxt    (k_nxt),
    .row_nxt  (row_nxt),
    .col_nxt  (col_nxt),
    .k_last   (k_last),
    .tile_last(tile_last)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    cnt_clr   = 1'b0;
    k_inc     = 1'b0;
    tile_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRIME;
          cnt_clr = 1'b1;
        end
      end
      ST_PRIME:    state_d = ST_RUN;
      ST_RUN: begin
        if (step_done) begin
          if (k_last) begin
            state_d = ST_DRAIN;
          end else begin
            k_inc   = 1'b1;
            state_d = ST_STEP_CLR;
          end
        end
      end
      ST_STEP_CLR: state_d = ST_RUN;
      ST_DRAIN: begin
        if (acc_done) begin
          state_d   = ST_EMIT;
          out_row_d = row;
          out_col_d = col;
        end
      end
      ST_EMIT: begin
        // Stalled sink keeps us here with the core idle and addresses frozen.
        if (tile_if.out_ready) begin
          tile_inc = 1'b1;
          state_d  = tile_last ? ST_FIN : ST_PRIME;
        end
      end
      ST_FIN:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE && start) begin
      err_d = 1'b0;
    end else if (acc_done && !(state_q inside {ST_DRAIN, ST_EMIT})) begin
      err_d = 1'b1;
    end
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    ctrl_d    = ctrl_of(state_d);
    a_addrb_d = '0;
    b_addrb_d = '0;
    if (state_d != ST_IDLE) begin
      a_addrb_d = ADDR_WIDTH_A'(k_nxt + K_STRIDE * row_nxt);
      b_addrb_d = ADDR_WIDTH_B'(k_nxt + K_STRIDE * col_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      a_addrb_q <= '0;
      b_addrb_q <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      a_addrb_q <= a_addrb_d;
      b_addrb_q <= b_addrb_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      err_q     <= err_d;
    end
  end

  assign busy              = ctrl_q.busy;
  assign done              = ctrl_q.done;
  assign a_enb             = ctrl_q.enb;
  assign b_enb             = ctrl_q.enb;
  assign core_en           = ctrl_q.core_en;
  assign core_rst_n        = ctrl_q.core_rst_n;
  assign core_reset_acc    = ctrl_q.core_reset_acc;
  assign a_addrb           = a_addrb_q;
  assign b_addrb           = b_addrb_q;
  assign tile_if.out_valid = ctrl_q.out_valid;
  assign tile_if.out_row   = out_row_q;
  assign tile_if.out_col   = out_col_q;
  assign err               = err_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler with a small core responder and a tile monitor.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_matmul_tile_scheduler;

  localparam int unsigned K_STEPS   = 4;
  localparam int unsigned ROW_TILES = 2;
  localparam int unsigned COL_TILES = 3;
  localparam int unsigned N_TILES   = ROW_TILES * COL_TILES;
  localparam int          BOUND     = 2000;

  logic       clk, rst_n, start;
  logic       busy, done, a_enb, b_enb, core_en, core_rst_n, core_reset_acc;
  logic [7:0] a_addrb, b_addrb;
  logic       step_done, acc_done, err;

  matmul_tile_scheduler_if #(.CNT_WIDTH(16)) tile_if ();

  matmul_tile_scheduler #(
    .K_STEPS(K_STEPS), .ROW_TILES(ROW_TILES), .COL_TILES(COL_TILES),
    .ADDR_WIDTH_A(8), .ADDR_WIDTH_B(8), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .a_enb(a_enb), .b_enb(b_enb), .a_addrb(a_addrb), .b_addrb(b_addrb),
    .core_en(core_en), .core_rst_n(core_rst_n), .core_reset_acc(core_reset_acc),
    .step_done(step_done), .acc_done(acc_done), .tile_if(tile_if), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Core responder: step_done on the 3rd RUN cycle, acc_done on the 2nd DRAIN cycle.
  int resp_run   = 0;
  int resp_steps = 0;
  bit inject_acc = 1'b0;

  initial begin
    step_done = 1'b0;
    acc_done  = 1'b0;
    forever begin
      @(negedge clk);
      step_done = 1'b0;
      acc_done  = 1'b0;
      if (!core_reset_acc) resp_steps = 0;
      if (core_en) begin
        resp_run++;
        if (resp_steps < K_STEPS) begin
          if (resp_run == 3) begin
            step_done = 1'b1;
            resp_steps++;
            resp_run = 0;
            if (inject_acc) begin
              acc_done   = 1'b1;
              inject_acc = 1'b0;
            end
          end
        end else if (resp_run == 2) begin
          acc_done = 1'b1;
        end
      end else begin
        resp_run = 0;
      end
    end
  end

  // Monitor: accepted tiles, done pulses and per-tile clear/address activity.
  int         mon_beats, mon_dones;
  logic [15:0] beat_row [8];
  logic [15:0] beat_col [8];
  int         rstn_low [8];
  int         acc_low  [8];
  int         trace_n  [8];
  logic [7:0] a_tr [8][4];
  logic [7:0] b_tr [8][4];

  task automatic clear_mon();
    mon_beats = 0;
    mon_dones = 0;
    for (int t = 0; t < 8; t++) begin
      rstn_low[t] = 0;
      acc_low[t]  = 0;
      trace_n[t]  = 0;
      for (int k = 0; k < 4; k++) begin
        a_tr[t][k] = '0;
        b_tr[t][k] = '0;
      end
    end
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      #1;
      if (done) mon_dones++;
      if (busy && mon_beats < 8) begin
        if (!core_rst_n) rstn_low[mon_beats]++;
        if (!core_reset_acc) acc_low[mon_beats]++;
        if ((!core_rst_n || !core_reset_acc) && trace_n[mon_beats] < 4) begin
          a_tr[mon_beats][trace_n[mon_beats]] = a_addrb;
          b_tr[mon_beats][trace_n[mon_beats]] = b_addrb;
          trace_n[mon_beats]++;
        end
      end
      if (tile_if.out_valid && tile_if.out_ready) begin
        if (mon_beats < 8) begin
          beat_row[mon_beats] = tile_if.out_row;
          beat_col[mon_beats] = tile_if.out_col;
        end
        mon_beats++;
      end
    end
  end

  typedef enum int {W_DONE, W_VALID, W_BEAT1, W_RUN, W_DRAIN_T3} wait_e;

  task automatic wait_for(input wait_e w, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < BOUND && !hit; i++) begin
      @(negedge clk);
      #2;
      case (w)
        W_DONE:     hit = done;
        W_VALID:    hit = tile_if.out_valid;
        W_BEAT1:    hit = (mon_beats == 1);
        W_RUN:      hit = core_en;
        W_DRAIN_T3: hit = (mon_beats == 3) && core_en && (resp_steps == K_STEPS);
        default:    hit = 1'b0;
      endcase
    end
    check({tag, "_reached"}, hit, 1'b1);
  endtask

  task automatic start_job();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_job(input string tag);
    check({tag, "_beats"}, mon_beats, N_TILES);
    for (int t = 0; t < N_TILES; t++) begin
      check($sformatf("%s_row%0d", tag, t), beat_row[t], t / COL_TILES);
      check($sformatf("%s_col%0d", tag, t), beat_col[t], t % COL_TILES);
    end
    check({tag, "_dones"}, mon_dones, 1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    rst_n             = 1'b0;
    start             = 1'b0;
    tile_if.out_ready = 1'b1;
    settle(3);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_enb", {a_enb, b_enb}, 2'b00);
    check("rst_addr", {a_addrb, b_addrb}, 16'h0000);
    check("rst_core", {core_en, core_rst_n, core_reset_acc}, 3'b000);
    check("rst_valid", tile_if.out_valid, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain job: tile order, single done, clear counts and address trace.
    clear_mon();
    start_job();
    wait_for(W_DONE, "job1_done");
    settle(2);
    check("job1_busy_after", busy, 1'b0);
    check("job1_err", err, 1'b0);
    check_job("job1");
    for (int k = 0; k < K_STEPS; k++) begin
      check($sformatf("t5_a%0d", k), a_tr[5][k], 4 + k);
      check($sformatf("t5_b%0d", k), b_tr[5][k], 8 + k);
    end
    for (int t = 0; t < N_TILES; t++) begin
      check($sformatf("rstn_low_t%0d", t), rstn_low[t], K_STEPS - 1);
      check($sformatf("acc_low_t%0d", t), acc_low[t], 1);
    end

    // Sink stalls at tile (0,1).
    clear_mon();
    start_job();
    wait_for(W_BEAT1, "stall_beat1");
    @(negedge clk);
    tile_if.out_ready = 1'b0;
    wait_for(W_VALID, "stall_valid");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall_c%0d", i),
            {tile_if.out_valid, tile_if.out_row, tile_if.out_col, core_en, a_addrb, b_addrb},
            {1'b1, 16'd0, 16'd1, 1'b0, 8'd3, 8'd7});
      if (i < 9) settle(1);
    end
    @(negedge clk);
    tile_if.out_ready = 1'b1;
    wait_for(W_DONE, "stall_done");
    settle(2);
    check_job("stall");

    // start during RUN and during FIN is ignored; then a fresh job.
    clear_mon();
    start_job();
    wait_for(W_RUN, "ign_run");
    start_job();
    wait_for(W_DONE, "ign_done");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    settle(4);
    check("ign_busy_after", busy, 1'b0);
    check_job("ign");
    clear_mon();
    start_job();
    wait_for(W_DONE, "job2_done");
    settle(2);
    check_job("job2");

    // Reset pulse during DRAIN of tile (1,0).
    clear_mon();
    start_job();
    wait_for(W_DRAIN_T3, "rst_drain");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("midrst_busy", busy, 1'b0);
    check("midrst_core", {core_en, core_rst_n, core_reset_acc}, 3'b000);
    check("midrst_enb", a_enb, 1'b0);
    settle(5);
    check("midrst_no_done", mon_dones, 0);
    check("midrst_idle", busy, 1'b0);
    clear_mon();
    start_job();
    wait_for(W_DONE, "restart_done");
    settle(2);
    check_job("restart");

    // acc_done together with a step_done in RUN: err sticks, sequence unaffected.
    clear_mon();
    inject_acc = 1'b1;
    start_job();
    wait_for(W_DONE, "err_done");
    settle(2);
    check("err_sticky", err, 1'b1);
    check_job("errjob");
    clear_mon();
    start_job();
    #2;
    check("err_cleared", err, 1'b0);
    wait_for(W_DONE, "final_done");
    settle(2);
    check_job("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
